// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: forwarding select codes, shadow-slot type and slot match helper
package pipe_ctrl_pkg;
  localparam int RA_MAX_W = 8;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_HOLD    = 2'b11;
  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } slot_t;
  function automatic logic slot_hit(slot_t s, logic [RA_MAX_W-1:0] r, logic zero_hw);
    return s.valid && s.reg_write && (s.rd == r) && !(zero_hw && (r == '0));
  endfunction
endpackage

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: match and priority-encode the forwarding source for one operand
module fwd_src_sel
  import pipe_ctrl_pkg::*;
#(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [RA_MAX_W-1:0] r,
  input  logic                use_r,
  input  slot_t               ex,
  input  slot_t               mem,
  input  slot_t               wb,
  output logic [1:0]          sel,
  output logic                ex_hit
);
  logic hit_ex, hit_mem, hit_wb;
  always_comb begin
    hit_ex  = slot_hit(ex, r, ZERO_REG_HARDWIRED);
    hit_mem = slot_hit(mem, r, ZERO_REG_HARDWIRED);
    hit_wb  = slot_hit(wb, r, ZERO_REG_HARDWIRED);
    ex_hit  = use_r & hit_ex;
    sel     = !use_r ? FWD_REGFILE :
              hit_ex  ? FWD_MEM :
              hit_mem ? FWD_WB :
              hit_wb  ? FWD_HOLD : FWD_REGFILE;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects, load-use stall and flush bubble control
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W         = 5,
  parameter int CNT_W              = 16,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_en,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic [CNT_W-1:0]      stall_cnt
);
  slot_t ex_q, mem_q, wb_q, hold_q;
  slot_t ex_d, mem_d, wb_d, hold_d, id_slot;
  logic [1:0] fwd_a_sel_q, fwd_b_sel_q, fwd_a_sel_d, fwd_b_sel_d, a_sel, b_sel;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic a_ex_hit, b_ex_hit, load_use, kill;
  fwd_src_sel #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_sel_a (
    .r(RA_MAX_W'(id_rs1)), .use_r(id_use_rs1), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(a_sel), .ex_hit(a_ex_hit)
  );
  fwd_src_sel #(.ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)) u_sel_b (
    .r(RA_MAX_W'(id_rs2)), .use_r(id_use_rs2), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .sel(b_sel), .ex_hit(b_ex_hit)
  );
  always_comb begin
    load_use     = id_valid & ex_q.mem_read & (a_ex_hit | b_ex_hit);
    stall_if_id  = load_use & ~ex_flush;
    bubble_id_ex = load_use | ex_flush;
    kill         = bubble_id_ex | ~id_valid;
    id_slot      = '{valid: 1'b1, rd: RA_MAX_W'(id_rd), reg_write: id_reg_write, mem_read: id_mem_read};
    ex_d         = pipe_en ? (kill ? '0 : id_slot) : ex_q;
    mem_d        = pipe_en ? ex_q : mem_q;
    wb_d         = pipe_en ? mem_q : wb_q;
    hold_d       = pipe_en ? wb_q : hold_q;
    fwd_a_sel_d  = pipe_en ? (kill ? FWD_REGFILE : a_sel) : fwd_a_sel_q;
    fwd_b_sel_d  = pipe_en ? (kill ? FWD_REGFILE : b_sel) : fwd_b_sel_q;
    stall_cnt_d  = (pipe_en & stall_if_id & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      hold_q      <= '0;
      fwd_a_sel_q <= FWD_REGFILE;
      fwd_b_sel_q <= FWD_REGFILE;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      hold_q      <= hold_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign fwd_a_sel = fwd_a_sel_q;
  assign fwd_b_sel = fwd_b_sel_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: randomized and directed check of fwd_hazard_ctrl against a distance-based model
module tb_fwd_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pipe_en = 1'b0, id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, ex_flush = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall_if_id, bubble_id_ex;
  logic [CW-1:0] stall_cnt;
  int n_pass = 0, n_chk = 0;
  bit h_v[3], h_wr[3], h_ld[3];
  int h_rd[3];
  int exp_a = 0, exp_b = 0, exp_cnt = 0;
  int obs_stall, obs_bub;
  fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .ZERO_REG_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic bit hit(int d, int r);
    return h_v[d] && h_wr[d] && h_rd[d] == r && r != 0;
  endfunction
  function automatic int ref_sel(int r, bit u);
    int code[3] = '{2, 1, 3};
    if (!u) return 0;
    for (int d = 0; d < 3; d++) if (hit(d, r)) return code[d];
    return 0;
  endfunction
  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      h_v[d] = 0; h_wr[d] = 0; h_ld[d] = 0; h_rd[d] = 0;
    end
    exp_a = 0; exp_b = 0; exp_cnt = 0;
  endtask
  task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit wr, input bit ld, input bit fl, input bit en);
    bit lu, es, eb;
    @(negedge clk);
    id_valid = v; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = RW'(rd); id_reg_write = wr; id_mem_read = ld; ex_flush = fl; pipe_en = en;
    #1;
    lu = v && h_ld[0] && ((u1 && hit(0, rs1)) || (u2 && hit(0, rs2)));
    es = lu && !fl;
    eb = lu || fl;
    obs_stall = int'(stall_if_id);
    obs_bub = int'(bubble_id_ex);
    check("stall_if_id", obs_stall, int'(es));
    check("bubble_id_ex", obs_bub, int'(eb));
    if (en) begin
      bit k = eb || !v;
      exp_a = k ? 0 : ref_sel(rs1, u1);
      exp_b = k ? 0 : ref_sel(rs2, u2);
      if (es && exp_cnt < (1 << CW) - 1) exp_cnt++;
      for (int d = 2; d > 0; d--) begin
        h_v[d] = h_v[d-1]; h_wr[d] = h_wr[d-1]; h_ld[d] = h_ld[d-1]; h_rd[d] = h_rd[d-1];
      end
      h_v[0] = !k; h_wr[0] = !k && wr; h_ld[0] = !k && ld; h_rd[0] = rd;
    end
    @(posedge clk);
    #1;
    check("fwd_a_sel", int'(fwd_a_sel), exp_a);
    check("fwd_b_sel", int'(fwd_b_sel), exp_b);
    check("stall_cnt", int'(stall_cnt), exp_cnt);
  endtask
  task automatic alu(input int rs1, input int rs2, input int rd);
    step(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_a", int'(fwd_a_sel), 0);
    check("rst_b", int'(fwd_b_sel), 0);
    check("rst_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_clear();
    #12;
    check("por_a", int'(fwd_a_sel), 0);
    check("por_b", int'(fwd_b_sel), 0);
    check("por_cnt", int'(stall_cnt), 0);
    check("por_stall", int'(stall_if_id), 0);
    check("por_bub", int'(bubble_id_ex), 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu(0, 0, 3);
    alu(3, 5, 4);
    check("b2b_a", int'(fwd_a_sel), 2);
    check("b2b_b", int'(fwd_b_sel), 0);
    check("b2b_nostall", obs_stall, 0);
    alu(1, 2, 7);
    alu(1, 2, 12);
    alu(0, 7, 9);
    check("dist2_b", int'(fwd_b_sel), 1);
    alu(0, 7, 10);
    check("dist3_b", int'(fwd_b_sel), 3);
    step(1, 1, 1, 1, 0, 6, 1, 1, 0, 1);
    step(1, 6, 6, 1, 1, 8, 1, 0, 0, 1);
    check("lu_stall", obs_stall, 1);
    check("lu_bub", obs_bub, 1);
    check("lu_cnt", int'(stall_cnt), 1);
    alu(6, 6, 8);
    check("lu_nostall", obs_stall, 0);
    check("lu_a", int'(fwd_a_sel), 1);
    check("lu_b", int'(fwd_b_sel), 1);
    alu(1, 1, 0);
    alu(0, 2, 11);
    check("zero_a", int'(fwd_a_sel), 0);
    step(1, 1, 1, 1, 0, 6, 1, 1, 0, 1);
    step(1, 6, 6, 1, 1, 8, 1, 0, 1, 1);
    check("fl_stall", obs_stall, 0);
    check("fl_bub", obs_bub, 1);
    check("fl_cnt", int'(stall_cnt), 1);
    alu(13, 13, 14);
    alu(14, 13, 15);
    for (int i = 0; i < 3; i++) begin
      step(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, $urandom_range(0, 15), 1, 0, 0, 0);
      check("hold_a", int'(fwd_a_sel), 2);
      check("hold_cnt", int'(stall_cnt), 1);
    end
    step(1, 1, 1, 1, 0, 6, 1, 1, 0, 1);
    @(negedge clk);
    id_valid = 1; id_rs1 = 6; id_use_rs1 = 1; id_use_rs2 = 0; ex_flush = 0; pipe_en = 1;
    #1;
    check("pre_rst_stall", int'(stall_if_id), 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("mid_rst_a", int'(fwd_a_sel), 0);
    check("mid_rst_cnt", int'(stall_cnt), 0);
    check("mid_rst_stall", int'(stall_if_id), 0);
    check("mid_rst_bub", int'(bubble_id_ex), 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu(0, 0, 3);
    alu(3, 3, 4);
    check("post_rst_a", int'(fwd_a_sel), 2);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0, 0, 6, 1, 1, 0, 1);
      step(1, 0, 6, 0, 1, 8, 1, 0, 0, 1);
    end
    check("sat_cnt", int'(stall_cnt), 7);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
